// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter and sequencer for a 4:1 mux datapath built as a tree of
// 2:1 muxes. One lane at a time owns the shared output channel. Its beats are
// forwarded over a valid/ready handshake. After each grant, priority rotates
// so that the released lane ranks lowest in the next round.

module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [3:0]            in_last,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            select,
  output logic [3:0]            grant,
  output logic                  busy
);

  // Burst limit as a 4-bit constant so it compares directly with the beat counter.
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  select_r, select_s;
  logic [1:0]  ptr_r, ptr_s;
  logic [3:0]  grant_r, grant_s;
  logic [3:0]  beat_cnt_r, beat_cnt_s;

  logic              granted_s;
  logic [1:0]        winner_s;
  logic              sel_req_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              xfer_s;
  logic [3:0]        beat_next_s;

  // Lane slices of the packed input data bus.
  logic [DATA_W-1:0] lane0_s, lane1_s, lane2_s, lane3_s;
  // Leaf-level outputs of the 2:1 mux tree (steered by select bit 0).
  logic [DATA_W-1:0] leaf_data_lo_s, leaf_data_hi_s;
  logic              leaf_req_lo_s, leaf_req_hi_s;
  logic              leaf_last_lo_s, leaf_last_hi_s;

  // First requesting lane found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr_v;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_v + 2'(k);
      if (!found && req_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign lane0_s = in_data[0*DATA_W +: DATA_W];
  assign lane1_s = in_data[1*DATA_W +: DATA_W];
  assign lane2_s = in_data[2*DATA_W +: DATA_W];
  assign lane3_s = in_data[3*DATA_W +: DATA_W];

  // Mux tree: leaf level chooses within each pair, root chooses between the pairs.
  always_comb begin
    leaf_data_lo_s = select_r[0] ? lane1_s : lane0_s;
    leaf_data_hi_s = select_r[0] ? lane3_s : lane2_s;
    leaf_req_lo_s  = select_r[0] ? req[1] : req[0];
    leaf_req_hi_s  = select_r[0] ? req[3] : req[2];
    leaf_last_lo_s = select_r[0] ? in_last[1] : in_last[0];
    leaf_last_hi_s = select_r[0] ? in_last[3] : in_last[2];
    sel_data_s     = select_r[1] ? leaf_data_hi_s : leaf_data_lo_s;
    sel_req_s      = select_r[1] ? leaf_req_hi_s  : leaf_req_lo_s;
    sel_last_s     = select_r[1] ? leaf_last_hi_s : leaf_last_lo_s;
  end

  assign granted_s   = (state_r == GRANT);
  assign winner_s    = rr_pick(req, ptr_r);
  assign beat_next_s = beat_cnt_r + 4'd1;

  // Handshake datapath. It follows the registered grant, so an async reset
  // clears it at once. in_ready only flags a beat that is actually accepted.
  always_comb begin
    out_valid = granted_s & sel_req_s;
    out_last  = granted_s & sel_last_s;
    xfer_s    = granted_s & sel_req_s & out_ready;
    if (granted_s) begin
      out_data = sel_data_s;
    end else begin
      out_data = {DATA_W{1'b0}};
    end
    if (xfer_s) begin
      in_ready = grant_r;
    end else begin
      in_ready = 4'b0000;
    end
  end

  // Next-state logic: pick a winner in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_s    = state_r;
    select_s   = select_r;
    grant_s    = grant_r;
    ptr_s      = ptr_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          state_s    = GRANT;
          select_s   = winner_s;
          grant_s    = 4'b0001 << winner_s;
          beat_cnt_s = 4'd0;
        end else begin
          grant_s    = 4'b0000;
        end
      end
      GRANT: begin
        if (xfer_s) begin
          if (sel_last_s || (beat_next_s == MAX_BURST_C)) begin
            state_s    = IDLE;
            grant_s    = 4'b0000;
            ptr_s      = select_r + 2'd1;
            beat_cnt_s = 4'd0;
          end else begin
            beat_cnt_s = beat_next_s;
          end
        end else if (!sel_req_s) begin
          // The lane withdrew its request, so it gives up the channel.
          state_s    = IDLE;
          grant_s    = 4'b0000;
          ptr_s      = select_r + 2'd1;
          beat_cnt_s = 4'd0;
        end else begin
          // Stalled by the downstream side: hold the grant and the count.
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = 4'b0000;
        beat_cnt_s = 4'd0;
      end
    endcase
  end

  // State register holding FSM state, mux select, grant, priority pointer and beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      select_r   <= 2'b00;
      grant_r    <= 4'b0000;
      ptr_r      <= 2'd0;
      beat_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      select_r   <= select_s;
      grant_r    <= grant_s;
      ptr_r      <= ptr_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

  assign select = select_r;
  assign grant  = grant_r;
  assign busy   = granted_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter (DATA_W=8, MAX_BURST=4).
// Inputs are driven 2 time units after the rising edge. Outputs are checked
// 1 unit after that, well away from the next active edge.

module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  select;
  logic [3:0]  grant;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .select    (select),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    in_data   = 32'h0;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    in_data   = 32'h44332211;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=%b", out_valid, 1'b0); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if (select !== 2'b00) begin errors++; $display("FAIL reset_select got=%b exp=%b", select, 2'b00); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=%h", out_data, 8'h00); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    wait_edge();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=%b", grant, 4'b0001); end
    checks++; if (select !== 2'b00) begin errors++; $display("FAIL reset_first_select got=%b exp=%b", select, 2'b00); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got=%b exp=%b", busy, 1'b1); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got=%b exp=%b", out_valid, 1'b1); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL reset_first_data got=%h exp=%h", out_data, 8'h11); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_grant [9];
    logic [1:0] exp_sel [9];
    exp_grant = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_sel   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    req       = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_edge();
      checks++; if (grant !== exp_grant[i]) begin errors++; $display("FAIL rot_grant[%0d] got=%b exp=%b", i, grant, exp_grant[i]); end
      checks++; if (select !== exp_sel[i]) begin errors++; $display("FAIL rot_select[%0d] got=%0d exp=%0d", i, select, exp_sel[i]); end
      checks++; if (in_ready !== exp_grant[i]) begin errors++; $display("FAIL rot_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_grant[i]); end
    end
    req = 4'b0000;
    repeat (2) wait_edge();
  endtask

  task automatic test_burst_cap();
    do_reset();
    req       = 4'b0100;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    in_data[16 +: 8] = 8'h10;
    wait_edge();
    checks++; if (select !== 2'd2) begin errors++; $display("FAIL burst_select got=%0d exp=%0d", select, 2'd2); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL burst_grant[%0d] got=%b exp=%b", k, grant, 4'b0100); end
      checks++; if (out_data !== 8'(8'h10 + k)) begin errors++; $display("FAIL burst_data[%0d] got=%h exp=%h", k, out_data, 8'(8'h10 + k)); end
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL burst_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0100); end
      wait_edge();
      in_data[16 +: 8] = 8'(8'h11 + k);
    end
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL burst_release_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL burst_release_in_ready got=%b exp=%b", in_ready, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_release_busy got=%b exp=%b", busy, 1'b0); end
    // Pointer should now be 3: with every lane requesting, lane 3 wins.
    req = 4'b1111;
    wait_edge();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL burst_ptr_grant got=%b exp=%b", grant, 4'b1000); end
    checks++; if (select !== 2'd3) begin errors++; $display("FAIL burst_ptr_select got=%0d exp=%0d", select, 2'd3); end
    req = 4'b0000;
    repeat (2) wait_edge();
  endtask

  task automatic test_last_withdraw();
    do_reset();
    // A: lane 1 ends its burst on beat 2.
    req       = 4'b0010;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    in_data[8 +: 8] = 8'h5C;
    wait_edge();
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL last_beat1_in_ready got=%b exp=%b", in_ready, 4'b0010); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL last_beat1_out_last got=%b exp=%b", out_last, 1'b0); end
    wait_edge();
    in_last = 4'b0010;
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL last_beat2_grant got=%b exp=%b", grant, 4'b0010); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL last_beat2_out_last got=%b exp=%b", out_last, 1'b1); end
    wait_edge();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL last_release_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL last_release_busy got=%b exp=%b", busy, 1'b0); end
    in_last = 4'b0000;
    // B: lane 3 withdraws after one beat.
    req = 4'b1000;
    wait_edge();
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wd_beat1_in_ready got=%b exp=%b", in_ready, 4'b1000); end
    wait_edge();
    req = 4'b0000;
    #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wd_hold_grant got=%b exp=%b", grant, 4'b1000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wd_out_valid got=%b exp=%b", out_valid, 1'b0); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL wd_in_ready got=%b exp=%b", in_ready, 4'b0000); end
    wait_edge();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_release_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL wd_release_in_ready got=%b exp=%b", in_ready, 4'b0000); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req       = 4'b0001;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    in_data[0 +: 8] = 8'hA5;
    wait_edge();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=%b", c, out_valid, 1'b1); end
      checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", c, out_data, 8'hA5); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", c, in_ready, 4'b0000); end
      checks++; if (dut.beat_cnt_r !== 4'd0) begin errors++; $display("FAIL bp_beat_cnt[%0d] got=%0d exp=%0d", c, dut.beat_cnt_r, 4'd0); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bp_grant[%0d] got=%b exp=%b", c, grant, 4'b0001); end
      wait_edge();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready_in_ready got=%b exp=%b", in_ready, 4'b0001); end
    wait_edge();
    checks++; if (dut.beat_cnt_r !== 4'd1) begin errors++; $display("FAIL bp_after_beat_cnt got=%0d exp=%0d", dut.beat_cnt_r, 4'd1); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bp_after_grant got=%b exp=%b", grant, 4'b0001); end
    in_last = 4'b0001;
    wait_edge();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_release_grant got=%b exp=%b", grant, 4'b0000); end
    req     = 4'b0000;
    in_last = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req       = 4'b0100;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    in_data[16 +: 8] = 8'h20;
    wait_edge();
    wait_edge();
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ar_pre_grant got=%b exp=%b", grant, 4'b0100); end
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL ar_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=%b", out_valid, 1'b0); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL ar_in_ready got=%b exp=%b", in_ready, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL ar_out_data got=%h exp=%h", out_data, 8'h00); end
    checks++; if (select !== 2'b00) begin errors++; $display("FAIL ar_select got=%b exp=%b", select, 2'b00); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ar_regrant got=%b exp=%b", grant, 4'b0100); end
    checks++; if (dut.beat_cnt_r !== 4'd0) begin errors++; $display("FAIL ar_beat_cnt got=%0d exp=%0d", dut.beat_cnt_r, 4'd0); end
    checks++; if (dut.ptr_r !== 2'd0) begin errors++; $display("FAIL ar_ptr got=%0d exp=%0d", dut.ptr_r, 2'd0); end
    req = 4'b0000;
    repeat (2) wait_edge();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_burst_cap();
    test_last_withdraw();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
